// File: rtl/debug_rx_framer_if.sv
// -----------------------------------------------------------------------------
// debug_rx_framer_if
// Bundles the UART-side byte stream and the command handshake of the debug
// receive framer.
//   d_in      [7:0]  received byte, valid while rx_done is high
//   rx_done          byte-received level from the UART receiver
//   cmd_ack          consumer accepts the presented command
//   cmd       [7:0]  command byte of the accepted frame
//   operand   [31:0] right-aligned, zero-extended operand
//   cmd_valid        a frame is presented on cmd/operand
//   frame_err        one-cycle pulse: checksum error, bad class or timeout
//   overrun          one-cycle pulse: byte dropped while a command is held
// Modports: master = byte source / command consumer, slave = the framer.
// -----------------------------------------------------------------------------
interface debug_rx_framer_if;
   logic [7:0]  d_in;
   logic        rx_done;
   logic        cmd_ack;
   logic [7:0]  cmd;
   logic [31:0] operand;
   logic        cmd_valid;
   logic        frame_err;
   logic        overrun;

   modport master (
      output d_in, rx_done, cmd_ack,
      input  cmd, operand, cmd_valid, frame_err, overrun
   );

   modport slave (
      input  d_in, rx_done, cmd_ack,
      output cmd, operand, cmd_valid, frame_err, overrun
   );
endinterface

// File: rtl/debug_rx_framer.sv
// -----------------------------------------------------------------------------
// debug_rx_framer
// Assembles debug command frames from a UART byte stream:
//   HEADER, CMD, 0/1/4 operand bytes (MSB first), CHECKSUM
// CHECKSUM is the XOR of the command and operand bytes. An accepted frame is
// held on cmd/operand with cmd_valid until the consumer raises cmd_ack.
// Parameters:
//   HEADER   frame start byte
//   TIMEOUT  maximum clk cycles allowed between bytes inside a frame
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   bus      debug_rx_framer_if.slave (byte input, command handshake, errors)
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module debug_rx_framer #(
   parameter logic [7:0] HEADER  = 8'hA5,
   parameter int         TIMEOUT = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   debug_rx_framer_if.slave     bus
);

   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_OPER = 3'd2,
      ST_CHK  = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   // Operand byte count selected by the command class cmd[7:6].
   function automatic logic [2:0] oper_len(input logic [1:0] cls);
      logic [2:0] len;
      case (cls)
         2'b00:   len = 3'd0;
         2'b01:   len = 3'd1;
         2'b10:   len = 3'd4;
         default: len = 3'd0;
      endcase
      return len;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic              rx_done_d_r;
   logic [7:0]        cmd_r;
   logic [7:0]        cmd_nxt_s;
   logic [31:0]       operand_r;
   logic [31:0]       operand_nxt_s;
   logic [7:0]        chk_r;
   logic [7:0]        chk_nxt_s;
   logic [2:0]        cnt_r;
   logic [2:0]        cnt_nxt_s;
   logic [GAP_W-1:0]  gap_r;
   logic [GAP_W-1:0]  gap_nxt_s;
   logic [GAP_W-1:0]  gap_inc_s;
   logic              timeout_s;
   logic              byte_evt_s;
   logic              cmd_valid_r;
   logic              frame_err_r;
   logic              frame_err_nxt_s;
   logic              overrun_r;
   logic              overrun_nxt_s;

   // A byte is taken only on the first high cycle of rx_done; the receiver
   // may hold the level for many cycles.
   assign byte_evt_s = bus.rx_done & ~rx_done_d_r;

   // The gap counter is compared against its incremented value so the
   // timeout fires in the TIMEOUT-th idle cycle and the counter never wraps.
   assign gap_inc_s  = gap_r + GAP_ONE;
   assign timeout_s  = (gap_inc_s == GAP_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, datapath next values and error pulses.
   always_comb begin
      state_nxt_s     = state_r;
      cmd_nxt_s       = cmd_r;
      operand_nxt_s   = operand_r;
      chk_nxt_s       = chk_r;
      cnt_nxt_s       = cnt_r;
      gap_nxt_s       = {GAP_W{1'b0}};
      frame_err_nxt_s = 1'b0;
      overrun_nxt_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (byte_evt_s && (bus.d_in == HEADER)) begin
               state_nxt_s   = ST_CMD;
               operand_nxt_s = 32'h0000_0000;
               chk_nxt_s     = 8'h00;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end

         ST_CMD: begin
            if (byte_evt_s) begin
               cmd_nxt_s = bus.d_in;
               chk_nxt_s = bus.d_in;
               cnt_nxt_s = oper_len(bus.d_in[7:6]);
               if (bus.d_in[7:6] == 2'b11) begin
                  frame_err_nxt_s = 1'b1;
                  state_nxt_s     = ST_IDLE;
               end else if (oper_len(bus.d_in[7:6]) == 3'd0) begin
                  state_nxt_s     = ST_CHK;
               end else begin
                  state_nxt_s     = ST_OPER;
               end
            end else if (timeout_s) begin
               frame_err_nxt_s = 1'b1;
               state_nxt_s     = ST_IDLE;
            end else begin
               gap_nxt_s       = gap_inc_s;
            end
         end

         ST_OPER: begin
            if (byte_evt_s) begin
               operand_nxt_s = {operand_r[23:0], bus.d_in};
               chk_nxt_s     = chk_r ^ bus.d_in;
               cnt_nxt_s     = cnt_r - 3'd1;
               if (cnt_r == 3'd1) begin
                  state_nxt_s = ST_CHK;
               end else begin
                  state_nxt_s = ST_OPER;
               end
            end else if (timeout_s) begin
               frame_err_nxt_s = 1'b1;
               state_nxt_s     = ST_IDLE;
            end else begin
               gap_nxt_s       = gap_inc_s;
            end
         end

         ST_CHK: begin
            if (byte_evt_s) begin
               if (bus.d_in == chk_r) begin
                  state_nxt_s     = ST_HOLD;
               end else begin
                  frame_err_nxt_s = 1'b1;
                  state_nxt_s     = ST_IDLE;
               end
            end else if (timeout_s) begin
               frame_err_nxt_s = 1'b1;
               state_nxt_s     = ST_IDLE;
            end else begin
               gap_nxt_s       = gap_inc_s;
            end
         end

         ST_HOLD: begin
            // A byte arriving while the command is held is lost, even in the
            // cycle the consumer acknowledges.
            if (byte_evt_s) begin
               overrun_nxt_s = 1'b1;
            end else begin
               overrun_nxt_s = 1'b0;
            end
            if (bus.cmd_ack) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath, edge-detect and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_done_d_r <= 1'b0;
         cmd_r       <= 8'h00;
         operand_r   <= 32'h0000_0000;
         chk_r       <= 8'h00;
         cnt_r       <= 3'd0;
         gap_r       <= {GAP_W{1'b0}};
         cmd_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         rx_done_d_r <= bus.rx_done;
         cmd_r       <= cmd_nxt_s;
         operand_r   <= operand_nxt_s;
         chk_r       <= chk_nxt_s;
         cnt_r       <= cnt_nxt_s;
         gap_r       <= gap_nxt_s;
         cmd_valid_r <= (state_nxt_s == ST_HOLD);
         frame_err_r <= frame_err_nxt_s;
         overrun_r   <= overrun_nxt_s;
      end
   end

   assign bus.cmd       = cmd_r;
   assign bus.operand   = operand_r;
   assign bus.cmd_valid = cmd_valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_debug_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_debug_rx_framer
// Directed bench for debug_rx_framer. dut_a uses TIMEOUT=20 for the timeout
// case; dut_b uses a longer TIMEOUT so bytes can be held for 40 cycles.
// Both receive the same stimulus; each check names the instance it reads.
// -----------------------------------------------------------------------------
module tb_debug_rx_framer;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   ovr_b_cnt = 0;
   int   err_b_cnt = 0;

   always #5 clk = ~clk;

   debug_rx_framer_if bus_a ();
   debug_rx_framer_if bus_b ();

   debug_rx_framer #(.HEADER(8'hA5), .TIMEOUT(20)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   debug_rx_framer #(.HEADER(8'hA5), .TIMEOUT(64)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   // Count error pulses of dut_b so the held-byte case can prove none occurred.
   always @(posedge clk) begin
      if (bus_b.overrun === 1'b1) ovr_b_cnt <= ovr_b_cnt + 1;
      if (bus_b.frame_err === 1'b1) err_b_cnt <= err_b_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [7:0] d, input logic rx, input logic ack);
      bus_a.d_in = d;  bus_a.rx_done = rx;  bus_a.cmd_ack = ack;
      bus_b.d_in = d;  bus_b.rx_done = rx;  bus_b.cmd_ack = ack;
   endtask

   // Raise rx_done with byte b for 'hold' cycles, then drop it.
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clk); #1;
      set_in(b, 1'b1, 1'b0);
      repeat (hold) @(posedge clk);
      #1;
      set_in(b, 1'b0, 1'b0);
   endtask

   task automatic ack_cmd();
      @(posedge clk); #1;
      set_in(8'h00, 1'b0, 1'b1);
      @(posedge clk); #1;
      set_in(8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_cmd"},       {24'h0, bus_a.cmd},       32'h0);
      check_val({tag, "_operand"},   bus_a.operand,            32'h0);
      check_val({tag, "_cmd_valid"}, {31'h0, bus_a.cmd_valid}, 32'h0);
      check_val({tag, "_frame_err"}, {31'h0, bus_a.frame_err}, 32'h0);
      check_val({tag, "_overrun"},   {31'h0, bus_a.overrun},   32'h0);
   endtask

   initial begin
      logic [7:0] ck;
      int o0;
      int e0;

      reset = 1'b0;
      set_in(8'h00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      // Zero-operand command 10, checksum 10.
      send_byte(8'hA5, 1);
      send_byte(8'h10, 1);
      @(negedge clk);
      check_val("c0_not_yet_valid", {31'h0, bus_a.cmd_valid}, 32'h0);
      send_byte(8'h10, 1);
      @(negedge clk);
      check_val("c0_valid",   {31'h0, bus_a.cmd_valid}, 32'h1);
      check_val("c0_cmd",     {24'h0, bus_a.cmd},       32'h10);
      check_val("c0_operand", bus_a.operand,            32'h0);
      ack_cmd();
      @(negedge clk);
      check_val("c0_ack_clears", {31'h0, bus_a.cmd_valid}, 32'h0);

      // Four-byte operand; checksum is the XOR of command and operand bytes.
      ck = 8'h81 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
      send_byte(8'hA5, 1);
      send_byte(8'h81, 1);
      send_byte(8'hDE, 1);
      send_byte(8'hAD, 1);
      send_byte(8'hBE, 1);
      send_byte(8'hEF, 1);
      send_byte(ck, 1);
      @(negedge clk);
      check_val("c4_valid",   {31'h0, bus_a.cmd_valid}, 32'h1);
      check_val("c4_cmd",     {24'h0, bus_a.cmd},       32'h81);
      check_val("c4_operand", bus_a.operand,            32'hDEADBEEF);
      repeat (3) @(negedge clk);
      check_val("c4_still_valid", {31'h0, bus_a.cmd_valid}, 32'h1);
      ack_cmd();
      @(negedge clk);
      check_val("c4_ack_clears", {31'h0, bus_a.cmd_valid}, 32'h0);

      // Bad checksum: 40^7F = 3F, 00 sent.
      send_byte(8'hA5, 1);
      send_byte(8'h40, 1);
      send_byte(8'h7F, 1);
      send_byte(8'h00, 1);
      @(negedge clk);
      check_val("badck_err",      {31'h0, bus_a.frame_err}, 32'h1);
      check_val("badck_no_valid", {31'h0, bus_a.cmd_valid}, 32'h0);
      @(negedge clk);
      check_val("badck_err_pulse", {31'h0, bus_a.frame_err}, 32'h0);

      // Same frame with the right checksum; 1-byte operand zero-extended.
      send_byte(8'hA5, 1);
      send_byte(8'h40, 1);
      send_byte(8'h7F, 1);
      send_byte(8'h3F, 1);
      @(negedge clk);
      check_val("c1_valid",   {31'h0, bus_a.cmd_valid}, 32'h1);
      check_val("c1_operand", bus_a.operand,            32'h0000007F);

      // Byte while held: overrun pulse, command unchanged.
      send_byte(8'h55, 1);
      @(negedge clk);
      check_val("hold_overrun",   {31'h0, bus_a.overrun},   32'h1);
      check_val("hold_cmd",       {24'h0, bus_a.cmd},       32'h40);
      check_val("hold_operand",   bus_a.operand,            32'h0000007F);
      check_val("hold_valid",     {31'h0, bus_a.cmd_valid}, 32'h1);
      @(negedge clk);
      check_val("hold_overrun_pulse", {31'h0, bus_a.overrun}, 32'h0);

      // Byte and ack in the same cycle: dropped with overrun, back to idle.
      @(posedge clk); #1;
      set_in(8'h66, 1'b1, 1'b1);
      @(posedge clk); #1;
      set_in(8'h66, 1'b0, 1'b0);
      @(negedge clk);
      check_val("ackbyte_overrun", {31'h0, bus_a.overrun},   32'h1);
      check_val("ackbyte_invalid", {31'h0, bus_a.cmd_valid}, 32'h0);

      // Timeout: header then silence; error in the 20th idle cycle.
      send_byte(8'hA5, 1);
      repeat (19) @(posedge clk);
      @(negedge clk);
      check_val("tmo_not_early", {31'h0, bus_a.frame_err}, 32'h0);
      @(negedge clk);
      check_val("tmo_err",       {31'h0, bus_a.frame_err}, 32'h1);
      @(negedge clk);
      check_val("tmo_err_pulse", {31'h0, bus_a.frame_err}, 32'h0);

      // Command class 11 is rejected.
      send_byte(8'hA5, 1);
      send_byte(8'hC0, 1);
      @(negedge clk);
      check_val("class11_err", {31'h0, bus_a.frame_err}, 32'h1);
      // Back in idle: a fresh frame decodes.
      send_byte(8'hA5, 1);
      send_byte(8'h10, 1);
      send_byte(8'h10, 1);
      @(negedge clk);
      check_val("after_err_valid", {31'h0, bus_a.cmd_valid}, 32'h1);
      ack_cmd();

      // rx_done held 40 cycles per byte on dut_b.
      do_reset();
      @(negedge clk);
      o0 = ovr_b_cnt;
      e0 = err_b_cnt;
      send_byte(8'hA5, 40);
      send_byte(8'h10, 40);
      send_byte(8'h10, 40);
      @(negedge clk);
      check_val("long_valid",   {31'h0, bus_b.cmd_valid}, 32'h1);
      check_val("long_cmd",     {24'h0, bus_b.cmd},       32'h10);
      check_val("long_overrun", ovr_b_cnt - o0,           32'h0);
      check_val("long_err",     err_b_cnt - e0,           32'h0);

      // Reset in the middle of a frame abandons it silently.
      do_reset();
      send_byte(8'hA5, 1);
      send_byte(8'h81, 1);
      send_byte(8'hDE, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_val("midrst_no_err", {31'h0, bus_a.frame_err}, 32'h0);
      send_byte(8'hA5, 1);
      send_byte(8'h81, 1);
      send_byte(8'hDE, 1);
      send_byte(8'hAD, 1);
      send_byte(8'hBE, 1);
      send_byte(8'hEF, 1);
      send_byte(ck, 1);
      @(negedge clk);
      check_val("postrst_valid",   {31'h0, bus_a.cmd_valid}, 32'h1);
      check_val("postrst_operand", bus_a.operand,            32'hDEADBEEF);
      ack_cmd();

      // rx_done high across reset release counts as a byte event.
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(8'hA5, 1'b1, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      set_in(8'hA5, 1'b0, 1'b0);
      send_byte(8'h10, 1);
      send_byte(8'h10, 1);
      @(negedge clk);
      check_val("rel_high_valid", {31'h0, bus_a.cmd_valid}, 32'h1);
      check_val("rel_high_cmd",   {24'h0, bus_a.cmd},       32'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
